// File: rtl/sram_req_bridge_if.sv
// Signal bundle between a CPU-side requester, the sram_req_bridge and a
// synchronous SRAM. The bridge uses the slave view; the environment uses master.
interface sram_req_bridge_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [31:0] req_addr;
    logic [3:0]  req_wstrb;
    logic [31:0] req_wdata;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_wr;
    logic        rsp_err;

    logic        sram_ren;
    logic [31:0] sram_raddr;
    logic [31:0] sram_rdata;
    logic [3:0]  sram_wen;
    logic [31:0] sram_waddr;
    logic [31:0] sram_wdata;

    modport slave (
        input  req_valid, req_wr, req_addr, req_wstrb, req_wdata,
        input  rsp_ready, sram_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_wr, rsp_err,
        output sram_ren, sram_raddr, sram_wen, sram_waddr, sram_wdata
    );

    modport master (
        output req_valid, req_wr, req_addr, req_wstrb, req_wdata,
        output rsp_ready, sram_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_wr, rsp_err,
        input  sram_ren, sram_raddr, sram_wen, sram_waddr, sram_wdata
    );
endinterface

// File: rtl/sram_req_bridge.sv
// Single-outstanding request/response bridge onto a synchronous SRAM with a
// one-cycle registered read port and byte-masked write port.
module sram_req_bridge #(
    parameter int ADDR_WIDTH = 20
) (
    input  logic               aclk,
    input  logic               aresetn,
    sram_req_bridge_if.slave   bus
);
    typedef enum logic [2:0] {IDLE, RD, RDW, WR, RSP} state_t;

    state_t state;
    logic   ready_q;
    logic   addr_bad;
    logic [31:0] word_addr;

    // ready is forced low while reset is held, even though the register is already set
    assign bus.req_ready = ready_q & aresetn;
    assign addr_bad      = (bus.req_addr >> ADDR_WIDTH) != 32'd0;
    assign word_addr     = {bus.req_addr[31:2], 2'b00};

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state          <= IDLE;
            ready_q        <= 1'b1;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_rdata  <= '0;
            bus.rsp_wr     <= 1'b0;
            bus.rsp_err    <= 1'b0;
            bus.sram_ren   <= 1'b0;
            bus.sram_raddr <= '0;
            bus.sram_wen   <= '0;
            bus.sram_waddr <= '0;
            bus.sram_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        ready_q <= 1'b0;
                        if (addr_bad) begin
                            state         <= RSP;
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_err   <= 1'b1;
                            bus.rsp_wr    <= bus.req_wr;
                            bus.rsp_rdata <= '0;
                        end else if (!bus.req_wr) begin
                            state          <= RD;
                            bus.sram_ren   <= 1'b1;
                            bus.sram_raddr <= word_addr;
                        end else if (bus.req_wstrb != 4'b0000) begin
                            state          <= WR;
                            bus.sram_wen   <= bus.req_wstrb;
                            bus.sram_waddr <= word_addr;
                            bus.sram_wdata <= bus.req_wdata;
                        end else begin
                            // empty strobe: acknowledge without touching the SRAM
                            state         <= RSP;
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_err   <= 1'b0;
                            bus.rsp_wr    <= 1'b1;
                            bus.rsp_rdata <= '0;
                        end
                    end
                end
                RD: begin
                    state          <= RDW;
                    bus.sram_ren   <= 1'b0;
                    bus.sram_raddr <= '0;
                end
                RDW: begin
                    state         <= RSP;
                    bus.rsp_valid <= 1'b1;
                    bus.rsp_rdata <= bus.sram_rdata;
                    bus.rsp_wr    <= 1'b0;
                    bus.rsp_err   <= 1'b0;
                end
                WR: begin
                    state          <= RSP;
                    bus.sram_wen   <= '0;
                    bus.sram_waddr <= '0;
                    bus.sram_wdata <= '0;
                    bus.rsp_valid  <= 1'b1;
                    bus.rsp_rdata  <= '0;
                    bus.rsp_wr     <= 1'b1;
                    bus.rsp_err    <= 1'b0;
                end
                RSP: begin
                    if (bus.rsp_ready) begin
                        state         <= IDLE;
                        ready_q       <= 1'b1;
                        bus.rsp_valid <= 1'b0;
                        bus.rsp_rdata <= '0;
                        bus.rsp_wr    <= 1'b0;
                        bus.rsp_err   <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sram_req_bridge.sv
// Directed and randomised checks of sram_req_bridge against a byte-masked SRAM
// model and a separate reference memory.
module tb_sram_req_bridge;
    logic clk = 1'b0;
    logic aresetn;
    always #5 clk = ~clk;

    sram_req_bridge_if bus ();

    sram_req_bridge #(.ADDR_WIDTH(20)) dut (
        .aclk    (clk),
        .aresetn (aresetn),
        .bus     (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int ren_cnt  = 0;
    int wen_cnt  = 0;
    int rsp_cnt  = 0;

    logic [31:0] sram_mem [0:255];
    logic [31:0] ref_mem  [0:255];

    // SRAM model: registered read, byte-masked write, cleared while reset is held
    always @(posedge clk) begin
        if (!aresetn) begin
            for (int i = 0; i < 256; i++) sram_mem[i] <= '0;
        end else begin
            for (int b = 0; b < 4; b++)
                if (bus.sram_wen[b])
                    sram_mem[bus.sram_waddr[9:2]][8*b +: 8] <= bus.sram_wdata[8*b +: 8];
        end
        if (bus.sram_ren) bus.sram_rdata <= sram_mem[bus.sram_raddr[9:2]];
    end

    always @(posedge clk) begin
        if (bus.sram_ren) ren_cnt <= ren_cnt + 1;
        if (bus.sram_wen != 4'b0000) wen_cnt <= wen_cnt + 1;
        if (aresetn && bus.rsp_valid && bus.rsp_ready) rsp_cnt <= rsp_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request for a single edge; returns one step after the acceptance edge.
    task automatic start(input logic wr, input logic [31:0] addr, input logic [3:0] strb,
                         input logic [31:0] data);
        bus.req_wr    = wr;
        bus.req_addr  = addr;
        bus.req_wstrb = strb;
        bus.req_wdata = data;
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic check_all_idle(input string tag);
        check({tag, "_rsp_valid"},  32'(bus.rsp_valid), 32'd0);
        check({tag, "_rsp_rdata"},  bus.rsp_rdata,      32'd0);
        check({tag, "_rsp_wr"},     32'(bus.rsp_wr),    32'd0);
        check({tag, "_rsp_err"},    32'(bus.rsp_err),   32'd0);
        check({tag, "_sram_ren"},   32'(bus.sram_ren),  32'd0);
        check({tag, "_sram_raddr"}, bus.sram_raddr,     32'd0);
        check({tag, "_sram_wen"},   32'(bus.sram_wen),  32'd0);
        check({tag, "_sram_waddr"}, bus.sram_waddr,     32'd0);
        check({tag, "_sram_wdata"}, bus.sram_wdata,     32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap_a, snap_b, rc0;
        logic        r_wr;
        logic [7:0]  r_idx;
        logic [3:0]  r_strb;
        logic [31:0] r_data;
        logic [31:0] r_addr;

        aresetn       = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_wr    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wstrb = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;
        tick();
        tick();
        check("rst_req_ready_low", 32'(bus.req_ready), 32'd0);
        check_all_idle("rst");
        aresetn = 1'b1;
        #1;
        check("rst_req_ready_high", 32'(bus.req_ready), 32'd1);

        // full-word write that seeds the read test
        bus.rsp_ready = 1'b1;
        start(1'b1, 32'h0000_0104, 4'hF, 32'hDEAD_BEEF);
        check("seed_wen", 32'(bus.sram_wen), 32'hF);
        tick();
        check("seed_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        tick();
        check("seed_back_idle", 32'(bus.req_ready), 32'd1);

        // read 0x104 with 3-cycle latency, then hold the response
        bus.rsp_ready = 1'b0;
        snap_a = ren_cnt;
        start(1'b0, 32'h0000_0104, 4'h0, 32'h0);
        check("rd_c1_ren",       32'(bus.sram_ren),  32'd1);
        check("rd_c1_raddr",     bus.sram_raddr,     32'h104);
        check("rd_c1_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rd_c1_req_ready", 32'(bus.req_ready), 32'd0);
        tick();
        check("rd_c2_ren",       32'(bus.sram_ren),  32'd0);
        check("rd_c2_raddr",     bus.sram_raddr,     32'd0);
        check("rd_c2_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        tick();
        check("rd_c3_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("rd_c3_rdata",     bus.rsp_rdata,      32'hDEAD_BEEF);
        check("rd_c3_wr",        32'(bus.rsp_wr),    32'd0);
        check("rd_c3_err",       32'(bus.rsp_err),   32'd0);
        check("rd_ren_pulses",   ren_cnt - snap_a,   32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            check("hold_rdata",     bus.rsp_rdata,      32'hDEAD_BEEF);
            check("hold_req_ready", 32'(bus.req_ready), 32'd0);
        end
        // a request offered during RSP must wait until after the return to IDLE
        bus.req_wr    = 1'b0;
        bus.req_addr  = 32'h0000_0104;
        bus.req_valid = 1'b1;
        bus.rsp_ready = 1'b1;
        tick();
        check("rel_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rel_req_ready", 32'(bus.req_ready), 32'd1);
        check("rel_ren_none",  32'(bus.sram_ren),  32'd0);
        tick();
        bus.req_valid = 1'b0;
        check("next_acc_ren", 32'(bus.sram_ren), 32'd1);
        tick();
        tick();
        check("next_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
        tick();

        // partial-strobe write to an unaligned address
        start(1'b1, 32'h0000_0203, 4'b0110, 32'h1122_3344);
        check("wr_c1_wen",       32'(bus.sram_wen),  32'h6);
        check("wr_c1_waddr",     bus.sram_waddr,     32'h200);
        check("wr_c1_wdata",     bus.sram_wdata,     32'h1122_3344);
        check("wr_c1_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        tick();
        check("wr_c2_wen",       32'(bus.sram_wen),  32'd0);
        check("wr_c2_waddr",     bus.sram_waddr,     32'd0);
        check("wr_c2_wdata",     bus.sram_wdata,     32'd0);
        check("wr_c2_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("wr_c2_rsp_wr",    32'(bus.rsp_wr),    32'd1);
        check("wr_c2_rdata",     bus.rsp_rdata,      32'd0);
        check("wr_c2_err",       32'(bus.rsp_err),   32'd0);
        tick();
        start(1'b0, 32'h0000_0200, 4'h0, 32'h0);
        tick();
        tick();
        check("wr_readback", bus.rsp_rdata, 32'h0022_3300);
        tick();

        // out-of-range read
        snap_a = ren_cnt;
        start(1'b0, 32'h0010_0000, 4'h0, 32'h0);
        check("err_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("err_flag",      32'(bus.rsp_err),   32'd1);
        check("err_rdata",     bus.rsp_rdata,      32'd0);
        check("err_wr",        32'(bus.rsp_wr),    32'd0);
        tick();
        check("err_no_ren", ren_cnt - snap_a, 32'd0);

        // write with empty strobe
        snap_b = wen_cnt;
        start(1'b1, 32'h0000_0010, 4'h0, 32'hFFFF_FFFF);
        check("z_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("z_err",       32'(bus.rsp_err),   32'd0);
        check("z_wr",        32'(bus.rsp_wr),    32'd1);
        tick();
        check("z_no_wen", wen_cnt - snap_b, 32'd0);

        // reset while in RD
        start(1'b0, 32'h0000_0104, 4'h0, 32'h0);
        check("rstrd_in_rd", 32'(bus.sram_ren), 32'd1);
        aresetn = 1'b0;
        tick();
        check("rstrd_req_ready_low", 32'(bus.req_ready), 32'd0);
        check_all_idle("rstrd");
        aresetn = 1'b1;
        #1;
        check("rstrd_req_ready_high", 32'(bus.req_ready), 32'd1);
        snap_a = ren_cnt;
        rc0    = rsp_cnt;
        repeat (4) tick();
        check("rstrd_no_ren", ren_cnt - snap_a, 32'd0);
        check("rstrd_no_rsp", rsp_cnt - rc0,    32'd0);
        check_all_idle("rstrd_after");

        // reset while in WR
        start(1'b1, 32'h0000_0300, 4'hF, 32'hCAFE_F00D);
        check("rstwr_in_wr", 32'(bus.sram_wen), 32'hF);
        aresetn = 1'b0;
        tick();
        check("rstwr_req_ready_low", 32'(bus.req_ready), 32'd0);
        check_all_idle("rstwr");
        aresetn = 1'b1;
        #1;
        snap_b = wen_cnt;
        rc0    = rsp_cnt;
        repeat (4) tick();
        check("rstwr_no_wen", wen_cnt - snap_b, 32'd0);
        check("rstwr_no_rsp", rsp_cnt - rc0,    32'd0);
        check_all_idle("rstwr_after");

        // back-to-back random traffic over a small window of words
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        rc0 = rsp_cnt;
        for (int t = 0; t < 24; t++) begin
            r_wr   = 1'($urandom_range(0, 1));
            r_idx  = 8'($urandom_range(0, 15));
            r_strb = 4'($urandom_range(0, 15));
            r_data = $urandom;
            r_addr = {22'd0, r_idx, 2'($urandom_range(0, 3))};
            start(r_wr, r_addr, r_strb, r_data);
            for (int k = 0; k < 6; k++) if (!bus.rsp_valid) tick();
            check("rnd_rsp_seen", 32'(bus.rsp_valid), 32'd1);
            check("rnd_err",      32'(bus.rsp_err),   32'd0);
            if (r_wr) begin
                for (int b = 0; b < 4; b++)
                    if (r_strb[b]) ref_mem[r_idx][8*b +: 8] = r_data[8*b +: 8];
                check("rnd_wr_rdata", bus.rsp_rdata, 32'd0);
            end else begin
                check("rnd_rd_rdata", bus.rsp_rdata, ref_mem[r_idx]);
            end
            tick();
        end
        check("rnd_rsp_count", rsp_cnt - rc0, 32'd24);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sram_req_bridge.md
SRAM_REQ_BRIDGE -- requirements
Module: sram_req_bridge

Interface
REQ-001 Parameter ADDR_WIDTH, default 20, the number of low address bits that map onto the SRAM; higher bits must be zero for a legal access.
REQ-002 aclk  input  1  the single clock; all state changes on its rising edge.
REQ-003 aresetn  input  1  reset, synchronous and active-low.
REQ-004 req_valid  input  1  request offered by the CPU side.
REQ-005 req_ready  output  1  the bridge accepts a request.
REQ-006 req_wr  input  1  1 = write, 0 = read.
REQ-007 req_addr  input  32  byte address.
REQ-008 req_wstrb  input  4  byte enables for a write.
REQ-009 req_wdata  input  32  write data.
REQ-010 rsp_valid  output  1  a response is available.
REQ-011 rsp_ready  input  1  the consumer takes the response.
REQ-012 rsp_rdata  output  32  read data; 0 for writes and errors.
REQ-013 rsp_wr  output  1  the response belongs to a write.
REQ-014 rsp_err  output  1  the address was out of range; no SRAM access was made.
REQ-015 sram_ren  output  1  SRAM read enable; read data is returned on sram_rdata in the following cycle.
REQ-016 sram_raddr  output  32  SRAM read address.
REQ-017 sram_rdata  input  32  SRAM read data, registered by the SRAM.
REQ-018 sram_wen  output  4  SRAM byte write enables.
REQ-019 sram_waddr  output  32  SRAM write address.
REQ-020 sram_wdata  output  32  SRAM write data.

Function
REQ-021 The state machine SHALL have exactly five states: IDLE, RD, RDW, WR and RSP; at most one transaction SHALL be outstanding.
REQ-022 req_ready SHALL be 1 only in IDLE, and a request is accepted at an edge where req_valid && req_ready.
REQ-023 On acceptance, the bridge SHALL latch req_wr, the address as {req_addr[31:2],2'b00}, req_wstrb and req_wdata.
REQ-024 An accepted request with req_addr[31:ADDR_WIDTH] != 0 SHALL go IDLE->RSP with rsp_err=1 and rsp_rdata=0, and SHALL NOT assert sram_ren or sram_wen.
REQ-025 A legal read SHALL go IDLE->RD; in RD, sram_ren=1 and sram_raddr=the latched address, for exactly one cycle.
REQ-026 The read SHALL then go RD->RDW; at the end of RDW, sram_rdata SHALL be captured into rsp_rdata and the state SHALL go to RSP.
REQ-027 Read latency SHALL be 3 cycles: rsp_valid rises in the third cycle after the acceptance edge.
REQ-028 A legal write with req_wstrb != 0 SHALL go IDLE->WR; in WR, sram_wen=the latched strobe, sram_waddr=the latched address and sram_wdata=the latched data, for exactly one cycle; the state then goes to RSP.
REQ-029 Write latency SHALL be 2 cycles.
REQ-030 A legal write with req_wstrb == 0 SHALL go IDLE->RSP directly (latency 1) with no sram_wen pulse and rsp_err=0.
REQ-031 In RSP, rsp_valid SHALL be 1; rsp_rdata, rsp_wr and rsp_err SHALL hold stable while rsp_ready=0; the state SHALL return to IDLE at the edge where rsp_ready=1.
REQ-032 The earliest next acceptance SHALL be the edge after the return to IDLE, so there are no overlapping transactions.
REQ-033 Outside RD, sram_ren SHALL be 0 and sram_raddr SHALL be 0.
REQ-034 Outside WR, sram_wen SHALL be 0, and sram_waddr and sram_wdata SHALL be 0.
REQ-035 rsp_valid SHALL be 0 outside RSP.
REQ-036 req_* inputs SHALL be ignored whenever req_ready=0.

Reset
REQ-037 At an edge with aresetn=0, the state SHALL become IDLE and all outputs SHALL take these values in the next cycle: req_ready=1 (while aresetn stays high), rsp_valid=0, rsp_rdata=0, rsp_wr=0, rsp_err=0, sram_ren=0, sram_wen=0, and all address/data outputs 0.
REQ-038 Reset in any state, including RD, RDW, WR or RSP, SHALL drop the in-flight transaction with no response and no later sram_ren or sram_wen pulse.
REQ-039 During aresetn=0, req_ready SHALL be 0.

Verification
REQ-040 Read addr 0x0000_0104 with sram_rdata=0xDEADBEEF in RDW -> one sram_ren pulse with raddr 0x104; 3 cycles later rsp_valid=1, rsp_rdata=0xDEADBEEF, rsp_wr=0, rsp_err=0.
REQ-041 Write addr 0x0000_0203, wstrb=4'b0110, wdata=0x11223344 -> one sram_wen=4'b0110 pulse with waddr 0x200 and wdata 0x11223344; rsp_valid 2 cycles after acceptance with rsp_wr=1 and rsp_rdata=0.
REQ-042 Read addr 0x0010_0000 with ADDR_WIDTH=20 -> no SRAM access; rsp_err=1 one cycle after acceptance. Write with wstrb=0 -> no sram_wen; rsp_err=0 one cycle after acceptance.
REQ-043 Hold rsp_ready=0 for 5 cycles on a read response -> rsp_valid and rsp_rdata stay stable and req_ready=0 throughout; release -> IDLE, with the next request accepted one edge later.
REQ-044 Assert aresetn=0 for one edge while in RD, and again while in WR -> no response, no later sram_wen pulse, and all outputs at their REQ-037 values.
REQ-045 Random back-to-back reads and writes against a byte-masked SRAM model -> read data matches a reference memory and exactly one response is produced per accepted request.
